branch_resolve: RTL

//  Execute-stage branch resolver; produces the BTB training interface and the fetch redirect.
//  Per branch: compares the fetch-time prediction carried down the pipe (pred_en/taken/target/btb_index)

---
 rtl/cpu_bp_pkg.sv | 29 ++
 rtl/btb_alloc_ptr.sv | 39 +++
 rtl/branch_resolve.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/cpu_bp_pkg.sv
// Shared types for the branch predictor training path.
// Prediction/update bundles and resolver FSM states.
package cpu_bp_pkg;

    localparam int BTBNUM_DEF = 32;
    localparam int IDXW_DEF   = $clog2(BTBNUM_DEF);

    typedef struct packed {
        logic                en;
        logic                taken;
        logic [31:0]         target;
        logic [IDXW_DEF-1:0] index;
    } bp_pred_t;

    typedef struct packed {
        logic                error;
        logic                right;
        logic                tgt_err;
        logic [31:0]         target;
        logic [31:0]         pc;
        logic [IDXW_DEF-1:0] index;
    } bp_update_t;

    typedef enum logic {
        ST_IDLE,
        ST_REDIRECT
    } br_state_t;

endpackage

// File: rtl/btb_alloc_ptr.sv
// Round-robin victim pointer for BTB allocation.
// Advances on each miss allocation, wrapping at BTBNUM.
import cpu_bp_pkg::*;

module btb_alloc_ptr #(
    parameter int BTBNUM = BTBNUM_DEF,
    parameter int IDXW   = $clog2(BTBNUM)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            inc_i,
    output logic [IDXW-1:0] ptr_o
);

    logic [IDXW-1:0] ptr_q;
    logic [IDXW-1:0] ptr_d;

    // next victim: step forward, wrap after the last entry
    always_comb begin
        ptr_d = ptr_q;
        if (inc_i) begin
            if (ptr_q == IDXW'(BTBNUM - 1))
                ptr_d = '0;
            else
                ptr_d = ptr_q + IDXW'(1);
        end
    end

    // pointer register
    always_ff @(posedge clk) begin
        if (reset)
            ptr_q <= '0;
        else
            ptr_q <= ptr_d;
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/branch_resolve.sv
// Execute-stage branch resolver: BTB training pulses,
// held fetch redirect, and saturating event counters.
import cpu_bp_pkg::*;

module branch_resolve #(
    parameter int BTBNUM = BTBNUM_DEF,
    parameter int IDXW   = $clog2(BTBNUM),
    parameter int CNTW   = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ex_valid,
    input  logic            ex_stall,
    input  logic            ex_is_branch,
    input  logic [31:0]     ex_pc,
    input  logic            ex_actual_taken,
    input  logic [31:0]     ex_actual_target,
    input  logic            ex_pred_en,
    input  logic            ex_pred_taken,
    input  logic [31:0]     ex_pred_target,
    input  logic [IDXW-1:0] ex_btb_index,
    output logic            pre_error,
    output logic            pre_right,
    output logic            target_error,
    output logic [31:0]     right_target,
    output logic [31:0]     operate_pc,
    output logic [IDXW-1:0] operate_index,
    output logic            redirect_valid,
    output logic [31:0]     redirect_pc,
    input  logic            redirect_ready,
    output logic [CNTW-1:0] branch_cnt,
    output logic [CNTW-1:0] mispred_cnt
);

    bp_pred_t        pred;
    bp_update_t      upd_q, upd_d;
    br_state_t       state_q, state_d;
    logic [31:0]     redir_pc_q, redir_pc_d;
    logic [CNTW-1:0] br_cnt_q, br_cnt_d;
    logic [CNTW-1:0] mp_cnt_q, mp_cnt_d;
    logic [IDXW-1:0] alloc_ptr;

    logic            resolve;
    logic            pt;
    logic            tgt_diff;
    logic            br_mispred;
    logic            nb_mispred;
    logic            mispred;
    logic            hit_right;
    logic            alloc_inc;
    logic [31:0]     pc4;

    btb_alloc_ptr #(
        .BTBNUM (BTBNUM),
        .IDXW   (IDXW)
    ) u_alloc (
        .clk    (clk),
        .reset  (reset),
        .inc_i  (alloc_inc),
        .ptr_o  (alloc_ptr)
    );

    // bundle the fetch-time prediction carried down the pipe
    always_comb begin
        pred        = '0;
        pred.en     = ex_pred_en;
        pred.taken  = ex_pred_taken;
        pred.target = ex_pred_target;
        pred.index  = ex_btb_index;
    end

    // compare prediction against the resolved outcome
    always_comb begin
        resolve    = ex_valid & ~ex_stall & (state_q == ST_IDLE);
        pt         = pred.en & pred.taken;
        tgt_diff   = pred.target != ex_actual_target;
        br_mispred = ex_is_branch
                   & ((pt != ex_actual_taken)
                   | (pt & ex_actual_taken & tgt_diff));
        nb_mispred = ~ex_is_branch & pt;
        mispred    = br_mispred | nb_mispred;
        hit_right  = ex_is_branch & pred.en & ~br_mispred;
        alloc_inc  = resolve & br_mispred & ~pred.en;
        pc4        = ex_pc + 32'd4;
    end

    // BTB update: one-cycle pulses, fields hold between pulses
    always_comb begin
        upd_d         = upd_q;
        upd_d.error   = 1'b0;
        upd_d.right   = 1'b0;
        upd_d.tgt_err = 1'b0;
        if (resolve & (mispred | hit_right)) begin
            upd_d.error   = mispred;
            upd_d.right   = hit_right;
            upd_d.tgt_err = br_mispred
                          & (~pred.en
                          | (ex_actual_taken & tgt_diff));
            upd_d.target  = ex_actual_target;
            upd_d.pc      = ex_pc;
            upd_d.index   = pred.en ? pred.index : alloc_ptr;
        end
    end

    // redirect FSM: enter on a mispredict, leave on acceptance
    always_comb begin
        state_d    = state_q;
        redir_pc_d = redir_pc_q;
        unique case (state_q)
            ST_IDLE: begin
                if (resolve & mispred) begin
                    state_d    = ST_REDIRECT;
                    redir_pc_d = (ex_is_branch & ex_actual_taken)
                               ? ex_actual_target : pc4;
                end
            end
            ST_REDIRECT: begin
                if (redirect_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // saturating statistics counters
    always_comb begin
        br_cnt_d = br_cnt_q;
        mp_cnt_d = mp_cnt_q;
        if (resolve & ex_is_branch & ~(&br_cnt_q))
            br_cnt_d = br_cnt_q + CNTW'(1);
        if (resolve & mispred & ~(&mp_cnt_q))
            mp_cnt_d = mp_cnt_q + CNTW'(1);
    end

    // state registers; reset also aborts a pending redirect
    always_ff @(posedge clk) begin
        if (reset) begin
            upd_q      <= '0;
            state_q    <= ST_IDLE;
            redir_pc_q <= '0;
            br_cnt_q   <= '0;
            mp_cnt_q   <= '0;
        end else begin
            upd_q      <= upd_d;
            state_q    <= state_d;
            redir_pc_q <= redir_pc_d;
            br_cnt_q   <= br_cnt_d;
            mp_cnt_q   <= mp_cnt_d;
        end
    end

    assign pre_error      = upd_q.error;
    assign pre_right      = upd_q.right;
    assign target_error   = upd_q.tgt_err;
    assign right_target   = upd_q.target;
    assign operate_pc     = upd_q.pc;
    assign operate_index  = upd_q.index;
    assign redirect_valid = (state_q == ST_REDIRECT);
    assign redirect_pc    = redir_pc_q;
    assign branch_cnt     = br_cnt_q;
    assign mispred_cnt    = mp_cnt_q;

endmodule
